pc_redirect_ctrl: RTL and testbench
===================================

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width.
REQ-002 The block SHALL have parameter FLUSH_DEPTH, default 3, giving the number of wrong-path cycles squashed after a redirect; the legal range is 1-15.
REQ-003 The block SHALL have these ports:
- clk  in  1  the single clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- valid_step_4  in  1  a step-4 instruction is present.
- is_branch_step_4  in  1  the step-4 instruction is a conditional relative branch.
- is_jump_ext_step_4  in  1  the step-4 instruction is an absolute jump.
- cond_true_step_4  in  1  the branch condition holds.
- pc_plus_one_step_4  in  WIDTH  PC+1 of the step-4 instruction.
- imm_step_4  in  WIDTH  sign-extended branch offset.
- addr_step_4  in  WIDTH  absolute jump address.
- stall  in  1  freezes PC and fetch.
- is_load_PC  out  1  PC load enable to step 1.
- control_mux_for_PC  out  2  PC source select: 0 = PC+1, 1 = PC+1+IMM, 2 = external address; 3 is never driven.
- pc_plus_one_plus_IMM_step_4  out  WIDTH  registered branch target.
- ext_ADDR_step_4  out  WIDTH  registered jump target.
- flush  out  1  squashes steps 1-3.
- redirect_count  out  16  number of redirects taken.

Function
REQ-004 A redirect event SHALL be sampled on a rising edge when state=RUN and valid_step_4=1 and (is_jump_ext_step_4=1 or (is_branch_step_4=1 and cond_true_step_4=1)).
REQ-005 When both is_jump_ext_step_4 and is_branch_step_4 are 1, the jump SHALL take priority and the branch SHALL be ignored.
REQ-006 On the sampling edge, the block SHALL register pc_plus_one_plus_IMM_step_4 = (pc_plus_one_step_4 + imm_step_4) mod 2^WIDTH, and register ext_ADDR_step_4 = addr_step_4.
- Both target registers SHALL load on every redirect event, whichever source is selected.
- The addition SHALL wrap silently; 0xFFFFFFFF + 1 = 0x00000000.
REQ-007 The state machine SHALL have states RUN, REDIRECT and FLUSH.
- RUN to REDIRECT on a redirect event.
- REDIRECT to FLUSH on the first edge with stall=0.
- FLUSH to RUN when the flush counter reaches 0.
REQ-008 In RUN, outputs SHALL be: is_load_PC = ~stall, control_mux_for_PC = 0, flush = 0.
REQ-009 In REDIRECT, outputs SHALL be: is_load_PC = ~stall and control_mux_for_PC = 2 (jump) or 1 (branch), held stable until the state is left; flush SHALL be 1.
REQ-010 Redirect latency SHALL be one cycle: event at edge N; REDIRECT selection during cycle N+1; PC holds the target after edge N+1 if stall=0.
REQ-011 In REDIRECT, stall=1 SHALL hold the state, select and targets; the redirect SHALL NOT be lost.
REQ-012 On entry to FLUSH, a 4-bit counter SHALL load FLUSH_DEPTH-1 and decrement once per edge with stall=0.
- In FLUSH: flush = 1, is_load_PC = ~stall, control_mux_for_PC = 0.
REQ-013 In FLUSH and REDIRECT, valid_step_4 SHALL be ignored; no new redirect is sampled for these wrong-path instructions.
REQ-014 A redirect event coinciding with stall=1 in RUN SHALL still be sampled; the stall then holds REDIRECT per REQ-011.
REQ-015 redirect_count SHALL increment on each RUN-to-REDIRECT transition and saturate at 0xFFFF.
REQ-016 Total flush duration with no stall SHALL be 1 + FLUSH_DEPTH cycles, counting the REDIRECT cycle.

Reset
REQ-017 While rst=0, the block SHALL immediately and asynchronously drive:
- state = RUN, counter = 0, both target registers = 0, redirect_count = 0;
- is_load_PC = 0, control_mux_for_PC = 0, flush = 0.
REQ-018 Reset asserted mid-REDIRECT or mid-FLUSH SHALL abort the redirect; after release, the block SHALL resume in RUN with is_load_PC = ~stall.

Verification
REQ-019 Branch taken: pc_plus_one=0x10, imm=0x5, cond=1, valid=1 -> next cycle: mux=1, target=0x15, is_load_PC=1; then 3 cycles of flush=1; then RUN; count=1.
REQ-020 Branch not taken: cond=0 -> mux stays 0, flush stays 0, count unchanged.
REQ-021 Jump and branch both 1, addr=0x80 -> mux=2, ext_ADDR=0x80.
REQ-022 Wrap: pc_plus_one=0xFFFFFFFF, imm=0x1 -> target 0x00000000; imm=0xFFFFFFFE with pc_plus_one=0x3 -> target 0x1.
REQ-023 Stall held 2 cycles during REDIRECT -> mux=1 held, is_load_PC=0, flush=1; redirect completes when stall drops; a valid taken branch in FLUSH does not redirect.
REQ-024 rst=0 pulse during FLUSH -> flush=0, is_load_PC=0 immediately, count=0; after release, mux=0, is_load_PC=1.

Source files
------------

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: turns a taken branch or absolute jump in step 4 into a
// one-cycle PC redirect followed by a fixed-length squash of the wrong-path steps.
module pc_redirect_ctrl #(
  parameter int WIDTH       = 32,
  parameter int FLUSH_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_step_4,
  input  logic             is_branch_step_4,
  input  logic             is_jump_ext_step_4,
  input  logic             cond_true_step_4,
  input  logic [WIDTH-1:0] pc_plus_one_step_4,
  input  logic [WIDTH-1:0] imm_step_4,
  input  logic [WIDTH-1:0] addr_step_4,
  input  logic             stall,
  output logic             is_load_PC,
  output logic [1:0]       control_mux_for_PC,
  output logic [WIDTH-1:0] pc_plus_one_plus_IMM_step_4,
  output logic [WIDTH-1:0] ext_ADDR_step_4,
  output logic             flush,
  output logic [15:0]      redirect_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] flush_cnt;
  logic [3:0] flush_cnt_next;
  logic       sel_jump;
  logic       redirect_event;

  // Wrong-path instructions in REDIRECT/FLUSH are ignored because the event needs RUN.
  assign redirect_event = (state == RUN) && valid_step_4 &&
                          (is_jump_ext_step_4 || (is_branch_step_4 && cond_true_step_4));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // Targets load together on every event; the source select remembers jump priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_plus_one_plus_IMM_step_4 <= '0;
      ext_ADDR_step_4             <= '0;
      sel_jump                    <= 1'b0;
      redirect_count              <= 16'd0;
    end else if (redirect_event) begin
      pc_plus_one_plus_IMM_step_4 <= pc_plus_one_step_4 + imm_step_4;
      ext_ADDR_step_4             <= addr_step_4;
      sel_jump                    <= is_jump_ext_step_4;
      if (redirect_count != 16'hFFFF) begin
        redirect_count <= redirect_count + 16'd1;
      end
    end
  end

  // is_load_PC is gated by rst so the PC is frozen asynchronously while in reset.
  always_comb begin
    state_next         = state;
    flush_cnt_next     = flush_cnt;
    is_load_PC         = rst & ~stall;
    control_mux_for_PC = 2'd0;
    flush              = 1'b0;
    case (state)
      RUN: begin
        if (redirect_event) begin
          state_next = REDIRECT;
        end
      end
      REDIRECT: begin
        control_mux_for_PC = sel_jump ? 2'd2 : 2'd1;
        flush              = 1'b1;
        if (!stall) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (!stall) begin
          if (flush_cnt == 4'd0) begin
            state_next = RUN;
          end else begin
            flush_cnt_next = flush_cnt - 4'd1;
          end
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl: branch/jump redirects, wrap,
// stall during REDIRECT, ignored wrong-path events and asynchronous reset.
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        validStep4;
  logic        isBranchStep4;
  logic        isJumpStep4;
  logic        condTrueStep4;
  logic [31:0] pcPlusOneStep4;
  logic [31:0] immStep4;
  logic [31:0] addrStep4;
  logic        stall;
  logic        isLoadPc;
  logic [1:0]  muxPc;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic        flush;
  logic [15:0] redirectCount;

  int errorCount = 0;
  int checkCount = 0;

  pc_redirect_ctrl #(.WIDTH(32), .FLUSH_DEPTH(3)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .valid_step_4                (validStep4),
    .is_branch_step_4            (isBranchStep4),
    .is_jump_ext_step_4          (isJumpStep4),
    .cond_true_step_4            (condTrueStep4),
    .pc_plus_one_step_4          (pcPlusOneStep4),
    .imm_step_4                  (immStep4),
    .addr_step_4                 (addrStep4),
    .stall                       (stall),
    .is_load_PC                  (isLoadPc),
    .control_mux_for_PC          (muxPc),
    .pc_plus_one_plus_IMM_step_4 (branchTarget),
    .ext_ADDR_step_4             (jumpTarget),
    .flush                       (flush),
    .redirect_count              (redirectCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic br, input logic jmp, input logic cond,
                               input logic [31:0] pc1, input logic [31:0] imm,
                               input logic [31:0] addr, input logic stl);
    validStep4     = v;
    isBranchStep4  = br;
    isJumpStep4    = jmp;
    condTrueStep4  = cond;
    pcPlusOneStep4 = pc1;
    immStep4       = imm;
    addrStep4      = addr;
    stall          = stl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Idle through the REDIRECT-to-FLUSH edge and all three FLUSH cycles.
  task automatic drainFlush();
    idle();
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    checkOutput("reset_load", {31'b0, isLoadPc}, 32'd0);
    checkOutput("reset_mux", {30'b0, muxPc}, 32'd0);
    checkOutput("reset_flush", {31'b0, flush}, 32'd0);
    checkOutput("reset_count", {16'b0, redirectCount}, 32'd0);
    checkOutput("reset_btarget", branchTarget, 32'd0);
    checkOutput("reset_jtarget", jumpTarget, 32'd0);
    #12;
    rst = 1'b1;
    tick();
    checkOutput("run_load", {31'b0, isLoadPc}, 32'd1);
    checkOutput("run_mux", {30'b0, muxPc}, 32'd0);

    // Branch taken: 0x10 + 0x5
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h5, 32'h99, 1'b0);
    tick();
    idle();
    checkOutput("br_mux", {30'b0, muxPc}, 32'd1);
    checkOutput("br_target", branchTarget, 32'h15);
    checkOutput("br_jtarget", jumpTarget, 32'h99);
    checkOutput("br_load", {31'b0, isLoadPc}, 32'd1);
    checkOutput("br_flush_redirect", {31'b0, flush}, 32'd1);
    checkOutput("br_count", {16'b0, redirectCount}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("br_flush_%0d", i), {31'b0, flush}, 32'd1);
      checkOutput($sformatf("br_flush_mux_%0d", i), {30'b0, muxPc}, 32'd0);
    end
    tick();
    checkOutput("br_back_run", {31'b0, flush}, 32'd0);

    // Branch not taken
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h7, 32'h0, 1'b0);
    tick();
    checkOutput("nt_mux", {30'b0, muxPc}, 32'd0);
    checkOutput("nt_flush", {31'b0, flush}, 32'd0);
    checkOutput("nt_count", {16'b0, redirectCount}, 32'd1);

    // Jump beats branch
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h4, 32'h80, 1'b0);
    tick();
    checkOutput("jmp_mux", {30'b0, muxPc}, 32'd2);
    checkOutput("jmp_target", jumpTarget, 32'h80);
    checkOutput("jmp_btarget", branchTarget, 32'h34);
    checkOutput("jmp_count", {16'b0, redirectCount}, 32'd2);
    drainFlush();
    checkOutput("jmp_back_run", {31'b0, flush}, 32'd0);

    // Wrapping adds
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
    tick();
    checkOutput("wrap0_target", branchTarget, 32'h0);
    checkOutput("wrap0_mux", {30'b0, muxPc}, 32'd1);
    drainFlush();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h3, 32'hFFFFFFFE, 32'h0, 1'b0);
    tick();
    checkOutput("wrap1_target", branchTarget, 32'h1);
    checkOutput("wrap1_count", {16'b0, redirectCount}, 32'd4);
    drainFlush();

    // Event sampled under stall, stall held in REDIRECT
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h4, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 32'h500, 32'h0, 1'b1);
    checkOutput("stl_mux0", {30'b0, muxPc}, 32'd1);
    checkOutput("stl_load0", {31'b0, isLoadPc}, 32'd0);
    checkOutput("stl_flush0", {31'b0, flush}, 32'd1);
    checkOutput("stl_count", {16'b0, redirectCount}, 32'd5);
    tick();
    checkOutput("stl_mux1", {30'b0, muxPc}, 32'd1);
    checkOutput("stl_load1", {31'b0, isLoadPc}, 32'd0);
    checkOutput("stl_target", branchTarget, 32'h24);
    stall = 1'b0;
    #1;
    checkOutput("stl_release_load", {31'b0, isLoadPc}, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h40, 32'h0, 1'b0);
    checkOutput("stl_in_flush", {31'b0, flush}, 32'd1);
    tick();
    checkOutput("wp_flush1", {31'b0, flush}, 32'd1);
    checkOutput("wp_mux1", {30'b0, muxPc}, 32'd0);
    tick();
    checkOutput("wp_flush2", {31'b0, flush}, 32'd1);
    tick();
    idle();
    checkOutput("wp_run_flush", {31'b0, flush}, 32'd0);
    checkOutput("wp_count", {16'b0, redirectCount}, 32'd5);
    checkOutput("wp_target", branchTarget, 32'h24);

    // Reset pulse during FLUSH
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h50, 32'h1, 32'h0, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("pre_rst_flush", {31'b0, flush}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_flush", {31'b0, flush}, 32'd0);
    checkOutput("rst_load", {31'b0, isLoadPc}, 32'd0);
    checkOutput("rst_count", {16'b0, redirectCount}, 32'd0);
    #2;
    rst = 1'b1;
    tick();
    checkOutput("post_rst_mux", {30'b0, muxPc}, 32'd0);
    checkOutput("post_rst_load", {31'b0, isLoadPc}, 32'd1);
    checkOutput("post_rst_flush", {31'b0, flush}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
